// File: rtl/music_rom_arbiter.sv
// ----------------------------------------------------------------------------
// music_rom_arbiter
//
// Shares one single-port music ROM between several read requesters (YM
// player on index 0, sound-effect player, CPU loader/peeker). Each requester
// raises req_valid with an address and holds it until req_ready. At most one
// request is accepted per clock. The granted address is registered onto
// rom_addr. A tag for the granted requester then travels down a
// ROM_LATENCY-deep pipeline. When the tag reaches the end, that requester
// sees a one-cycle rsp_valid pulse while rsp_data carries rom_data.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   req_valid  per-requester read request, held until accepted
//   req_addr   packed addresses, requester i at [i*ROM_WIDTH +: ROM_WIDTH]
//   req_ready  one-hot combinational accept, forced low during reset
//   rsp_valid  one-hot response pulse, ROM_LATENCY cycles after accept
//   rsp_data   read data, pass-through of rom_data
//   rom_addr   registered ROM address
//   rom_data   ROM read data
//   busy       high while any accepted read is still in flight
// ----------------------------------------------------------------------------
module music_rom_arbiter #(
   parameter int ROM_WIDTH   = 17,
   parameter int NUM_REQ     = 3,
   parameter int ROM_LATENCY = 2,
   parameter bit PRIO0       = 1'b0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*ROM_WIDTH-1:0]   req_addr,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [7:0]                     rsp_data,
   output logic [ROM_WIDTH-1:0]           rom_addr,
   input  logic [7:0]                     rom_data,
   output logic                           busy
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

   // Round-robin candidate at distance k from the pointer. The explicit
   // wrap keeps the search correct when NUM_REQ is not a power of two.
   function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   logic [ID_W-1:0]                  ptr_q, ptr_d;
   logic [ROM_WIDTH-1:0]             rom_addr_q, rom_addr_d;
   logic [ROM_LATENCY-1:0]           tag_vld_q, tag_vld_d;
   logic [ROM_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;

   logic                             grant_any;
   logic [ID_W-1:0]                  grant_id;
   logic [NUM_REQ-1:0]               grant_vec;
   logic                             accept;

   // Arbitration: optional fixed priority for the YM player, otherwise
   // first valid requester after the last winner.
   always_comb begin
      logic [ID_W-1:0] cand;
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = '0;
      if (PRIO0 && req_valid[0]) begin
         grant_any = 1'b1;
         grant_id  = '0;
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = rr_index(ptr_q, k);
            if (!grant_any && req_valid[cand]) begin
               grant_any = 1'b1;
               grant_id  = cand;
            end
         end
      end
   end

   // Grants are suppressed in reset so no request is consumed by a cycle
   // whose pipeline state is about to be discarded.
   assign accept = grant_any && !reset;

   always_comb begin
      grant_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_vec[i] = accept && (grant_id == ID_W'(i));
      end
   end

   assign req_ready = grant_vec;

   always_comb begin
      rom_addr_d = rom_addr_q;
      ptr_d      = ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_vec[i]) begin
            rom_addr_d = req_addr[i*ROM_WIDTH +: ROM_WIDTH];
         end
      end
      if (accept) begin
         ptr_d = grant_id;
      end
   end

   // Tag pipeline shifts every cycle. Idle cycles shift in an empty tag, so
   // a tag reaches the last stage exactly ROM_LATENCY cycles after its accept.
   always_comb begin
      tag_vld_d    = '0;
      tag_id_d     = '0;
      tag_vld_d[0] = accept;
      tag_id_d[0]  = grant_id;
      for (int s = 1; s < ROM_LATENCY; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_id_d[s]  = tag_id_q[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= PTR_RST;
         rom_addr_q <= '0;
         tag_vld_q  <= '0;
         tag_id_q   <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rom_addr_q <= rom_addr_d;
         tag_vld_q  <= tag_vld_d;
         tag_id_q   <= tag_id_d;
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = tag_vld_q[ROM_LATENCY-1] && (tag_id_q[ROM_LATENCY-1] == ID_W'(i));
      end
   end

   assign rsp_data = rom_data;
   assign rom_addr = rom_addr_q;
   assign busy     = |tag_vld_q;

endmodule

// File: tb/tb_music_rom_arbiter.sv
module tb_music_rom_arbiter;

   localparam int AW = 17;
   localparam int N  = 3;
   localparam int L  = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // index 0: round-robin instance, index 1: PRIO0 instance
   logic [N-1:0]    vin  [2];
   logic [N*AW-1:0] apk  [2];
   logic [N-1:0]    rdy  [2];
   logic [N-1:0]    rv   [2];
   logic [7:0]      rd   [2];
   logic [7:0]      romd [2];
   logic [AW-1:0]   ra   [2];
   logic            bz   [2];

   music_rom_arbiter #(.ROM_WIDTH(AW), .NUM_REQ(N), .ROM_LATENCY(L), .PRIO0(1'b0)) u_rr (
      .clk(clk), .reset(reset), .req_valid(vin[0]), .req_addr(apk[0]),
      .req_ready(rdy[0]), .rsp_valid(rv[0]), .rsp_data(rd[0]),
      .rom_addr(ra[0]), .rom_data(romd[0]), .busy(bz[0]));

   music_rom_arbiter #(.ROM_WIDTH(AW), .NUM_REQ(N), .ROM_LATENCY(L), .PRIO0(1'b1)) u_p0 (
      .clk(clk), .reset(reset), .req_valid(vin[1]), .req_addr(apk[1]),
      .req_ready(rdy[1]), .rsp_valid(rv[1]), .rsp_data(rd[1]),
      .rom_addr(ra[1]), .rom_data(romd[1]), .busy(bz[1]));

   // ROM: one register stage behind rom_addr, data = addr[7:0] ^ A5
   always @(posedge clk) begin
      romd[0] <= ra[0][7:0] ^ 8'hA5;
      romd[1] <= ra[1][7:0] ^ 8'hA5;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: list of outstanding reads with the cycle they are due.
   typedef struct {
      int            d;
      int            due;
      int            id;
      logic [AW-1:0] addr;
   } rd_t;

   rd_t           mq[$];
   int            m_ptr [2];
   logic [AW-1:0] m_addr[2];
   int            exp_g [2];
   int            cyc = 0;

   function automatic logic [AW-1:0] addr_of(input int d, input int i);
      logic [N*AW-1:0] v;
      v = apk[d];
      return v[i*AW +: AW];
   endfunction

   task automatic eval_dut(input int d);
      int            g;
      logic [N-1:0]  exp_rdy;
      logic [N-1:0]  exp_rv;
      logic [7:0]    exp_rd;
      logic          exp_bz;
      g = -1;
      if (!reset) begin
         if (d == 1 && vin[d][0]) g = 0;
         else begin
            for (int k = 1; k <= N; k++) begin
               int idx;
               idx = (m_ptr[d] + k) % N;
               if (g < 0 && vin[d][idx]) g = idx;
            end
         end
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      check_eq($sformatf("ready[%0d]", d), 32'(rdy[d]), 32'(exp_rdy));

      exp_rv = '0;
      exp_rd = '0;
      exp_bz = 1'b0;
      foreach (mq[j]) begin
         if (mq[j].d == d) begin
            exp_bz = 1'b1;
            if (mq[j].due == cyc) begin
               exp_rv = N'(1) << mq[j].id;
               exp_rd = mq[j].addr[7:0] ^ 8'hA5;
            end
         end
      end
      if (!reset) begin
         check_eq($sformatf("rsp_valid[%0d]", d), 32'(rv[d]), 32'(exp_rv));
         if (exp_rv != '0) check_eq($sformatf("rsp_data[%0d]", d), 32'(rd[d]), 32'(exp_rd));
         check_eq($sformatf("busy[%0d]", d), 32'(bz[d]), 32'(exp_bz));
         check_eq($sformatf("rom_addr[%0d]", d), 32'(ra[d]), 32'(m_addr[d]));
      end

      for (int j = mq.size() - 1; j >= 0; j--) begin
         if (mq[j].d == d && (reset || mq[j].due == cyc)) mq.delete(j);
      end
      if (reset) begin
         m_ptr[d]  = N - 1;
         m_addr[d] = '0;
      end else if (g >= 0) begin
         rd_t e;
         e.d = d; e.due = cyc + L; e.id = g; e.addr = addr_of(d, g);
         mq.push_back(e);
         m_ptr[d]  = g;
         m_addr[d] = e.addr;
      end
      exp_g[d] = g;
   endtask

   // One clock: inputs already driven; check at the falling edge, then
   // return just after the next rising edge.
   task automatic step();
      @(negedge clk);
      eval_dut(0);
      eval_dut(1);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int d, input int i, input logic [AW-1:0] a);
      apk[d][i*AW +: AW] = a;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic rand_drive();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) begin
            if (vin[d][i] && exp_g[d] != i) begin
               if ($urandom_range(7) == 0) vin[d][i] = 1'b0;
            end else begin
               vin[d][i] = ($urandom_range(2) != 0);
               set_addr(d, i, AW'($urandom));
            end
         end
      end
   endtask

   initial begin
      reset  = 1'b1;
      vin[0] = '0; vin[1] = '0;
      apk[0] = '0; apk[1] = '0;
      exp_g[0] = -1; exp_g[1] = -1;
      m_ptr[0] = N - 1; m_ptr[1] = N - 1;
      m_addr[0] = '0; m_addr[1] = '0;
      repeat (3) step();
      reset = 1'b0;
      check_eq("reset_busy", 32'(bz[0]), 32'd0);
      check_eq("reset_rv", 32'(rv[0]), 32'd0);
      check_eq("reset_rom_addr", 32'(ra[0]), 32'd0);

      // single read from requester 0
      vin[0] = 3'b001; set_addr(0, 0, 17'h00013);
      step();
      vin[0] = '0;
      check_eq("t1_rom_addr", 32'(ra[0]), 32'h13);
      step();
      check_eq("t1_rsp_valid", 32'(rv[0]), 32'b001);
      check_eq("t1_rsp_data", 32'(rd[0]), 32'hB6);
      step();

      // all three continuously: 0,1,2,0,1,2
      pulse_reset();
      set_addr(0, 0, 17'h00100); set_addr(0, 1, 17'h00211); set_addr(0, 2, 17'h00322);
      vin[0] = 3'b111;
      for (int k = 0; k < 6; k++) begin
         step();
         check_eq("t2_grant_addr", 32'(ra[0]), 32'(addr_of(0, k % 3)));
      end
      vin[0] = '0;
      repeat (3) step();

      // PRIO0: requester 0 starves requester 1 until it drops
      set_addr(1, 0, 17'h0AAAA); set_addr(1, 1, 17'h15555);
      vin[1] = 3'b011;
      for (int k = 0; k < 10; k++) begin
         step();
         check_eq("t3_prio_addr", 32'(ra[1]), 32'h0AAAA);
      end
      vin[1] = 3'b010;
      step();
      check_eq("t3_req1_after_drop", 32'(ra[1]), 32'h15555);
      vin[1] = '0;
      repeat (3) step();

      // reset with two reads in flight
      pulse_reset();
      set_addr(0, 0, 17'h00042); set_addr(0, 1, 17'h00043);
      vin[0] = 3'b011;
      step();
      vin[0] = 3'b010;
      step();
      vin[0] = '0;
      pulse_reset();
      check_eq("t4_rv_after_rst", 32'(rv[0]), 32'd0);
      check_eq("t4_busy_after_rst", 32'(bz[0]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("t4_rv_quiet", 32'(rv[0]), 32'd0);
         check_eq("t4_busy_quiet", 32'(bz[0]), 32'd0);
      end
      set_addr(0, 0, 17'h00A00); set_addr(0, 1, 17'h00A11); set_addr(0, 2, 17'h00A22);
      vin[0] = 3'b111;
      step();
      check_eq("t4_first_grant0", 32'(ra[0]), 32'h00A00);
      vin[0] = '0;
      repeat (3) step();

      // pointer at 1 picks 2 before 0, then wraps 2 -> 0
      pulse_reset();
      vin[0] = 3'b010; set_addr(0, 1, 17'h00777);
      step();
      vin[0] = 3'b101; set_addr(0, 0, 17'h00100); set_addr(0, 2, 17'h00222);
      step();
      check_eq("t5_grant2", 32'(ra[0]), 32'h00222);
      vin[0] = 3'b001;
      step();
      check_eq("t5_wrap_grant0", 32'(ra[0]), 32'h00100);
      vin[0] = '0;
      repeat (3) step();

      // idle hold of rom_addr, busy tail
      vin[0] = 3'b001; set_addr(0, 0, 17'h1ABCD);
      step();
      vin[0] = '0;
      check_eq("t6_busy_t1", 32'(bz[0]), 32'd1);
      step();
      check_eq("t6_busy_t2", 32'(bz[0]), 32'd1);
      step();
      check_eq("t6_busy_t3", 32'(bz[0]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         check_eq("t6_addr_hold", 32'(ra[0]), 32'h1ABCD);
         step();
      end

      // randomized traffic with occasional resets
      for (int k = 0; k < 3000; k++) begin
         rand_drive();
         reset = ($urandom_range(255) == 0);
         step();
      end
      reset = 1'b0;
      vin[0] = '0; vin[1] = '0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
